// File: rtl/fpgnix_uart_pkg.sv
// Shared definitions for the UART TX arbiter slice.
//   TAG_NIBBLE : upper nibble of the channel tag byte sent ahead of each packet
//   state_t    : arbiter FSM states
//   make_tag   : builds the tag byte {TAG_NIBBLE, id}
package fpgnix_uart_pkg;

  localparam logic [3:0] TAG_NIBBLE = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TAG  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  function automatic logic [7:0] make_tag(input logic [3:0] id);
    return {TAG_NIBBLE, id};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector.
//   req     : request vector, one bit per requester
//   ptr     : last requester served; search starts at ptr+1 and wraps mod N
//   gnt_id  : index of the winning requester (0 when nothing is requested)
//   gnt_vld : 1 when at least one request is present
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] gnt_id,
  output logic            gnt_vld
);

  logic [ID_W-1:0] idx;

  // Walk from the lowest-priority slot (ptr itself) towards ptr+1 so that the
  // nearest requester after ptr is the last one written and therefore wins.
  always_comb begin
    gnt_id  = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int k = N; k >= 1; k--) begin
      idx = ID_W'((int'(ptr) + k) % N);
      if (req[idx]) begin
        gnt_id  = idx;
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX byte stream among N_REQ requesters, one packet per grant,
// round-robin. Optionally emits a channel tag byte {4'hA, id} before each packet.
//   clk_sys, rst        : clock and synchronous active-high reset
//   req_valid/req_data/req_last/req_ready : per-requester byte streams
//                         (requester i data on req_data[8*i+7:8*i])
//   tx_valid/tx_data/tx_ready : byte stream to the UART serializer
//   grant_id            : current / most recently granted requester
//   busy                : a grant is held
//   timeout_evt         : one-cycle pulse when an idle grant is forcibly released
module uart_tx_arbiter
  import fpgnix_uart_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter bit TAG_EN      = 1'b1,
  parameter int TIMEOUT_CYC = 1024,
  parameter int ID_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk_sys,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  input  logic               tx_ready,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic               timeout_evt
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t          state;
  state_t          state_nxt;
  logic [ID_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;
  logic [ID_W-1:0] arb_id;
  logic            arb_vld;

  logic [7:0]      req_bytes [N_REQ];
  logic            g_valid;
  logic            g_last;
  logic [7:0]      g_data;
  logic            pkt_done;
  logic            idle_expire;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign req_bytes[i] = req_data[8*i +: 8];
  end

  rr_arbiter #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_rr (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt_id  (arb_id),
    .gnt_vld (arb_vld)
  );

  assign g_valid = req_valid[grant_id];
  assign g_last  = req_last[grant_id];
  assign g_data  = req_bytes[grant_id];

  assign pkt_done = (state == ST_DATA) && g_valid && tx_ready && g_last;

  // A byte on offer always beats the idle timer, so a release never drops a
  // pending byte.
  assign idle_expire = (TIMEOUT_CYC != 0) && (state == ST_DATA) && !g_valid &&
                       (cnt == CNT_LAST);

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (arb_vld) state_nxt = TAG_EN ? ST_TAG : ST_DATA;
      ST_TAG:  if (tx_ready) state_nxt = ST_DATA;
      ST_DATA: if (pkt_done || idle_expire) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ptr starts at N_REQ-1 so requester 0 is first in line after reset.
  // The idle counter saturates rather than wrapping when the timeout is off.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      ptr      <= ID_W'(N_REQ - 1);
      grant_id <= '0;
      cnt      <= '0;
    end else begin
      if ((state == ST_IDLE) && arb_vld) begin
        grant_id <= arb_id;
      end
      if (pkt_done || idle_expire) begin
        ptr <= grant_id;
      end
      if ((state != ST_DATA) || g_valid) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // DATA is a pure combinational pass-through of the granted requester.
  always_comb begin
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    req_ready   = '0;
    busy        = (state != ST_IDLE);
    timeout_evt = idle_expire;
    unique case (state)
      ST_TAG: begin
        tx_valid = 1'b1;
        tx_data  = make_tag(4'(grant_id));
      end
      ST_DATA: begin
        tx_valid            = g_valid;
        tx_data             = g_data;
        req_ready[grant_id] = tx_ready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter. Instance dut: N_REQ=4, tags on, timeout 8.
// Instance dut1: N_REQ=1, tags off, timeout disabled. The expected byte stream
// for each phase is built from the round-robin rule over the queued packets.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [N-1:0] req_valid, req_last, req_ready;
  logic [8*N-1:0] req_data;
  logic         tx_valid, tx_ready, busy, timeout_evt;
  logic [7:0]   tx_data;
  logic [1:0]   grant_id;

  logic [0:0]   s_valid, s_last, s_ready, s_gid;
  logic [7:0]   s_data, s_txd;
  logic         s_txv, s_txr, s_busy, s_to;

  uart_tx_arbiter #(.N_REQ(N), .TAG_EN(1'b1), .TIMEOUT_CYC(TO)) dut (
    .clk_sys(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready), .grant_id(grant_id),
    .busy(busy), .timeout_evt(timeout_evt)
  );

  uart_tx_arbiter #(.N_REQ(1), .TAG_EN(1'b0), .TIMEOUT_CYC(0)) dut1 (
    .clk_sys(clk), .rst(rst), .req_valid(s_valid), .req_data(s_data),
    .req_last(s_last), .req_ready(s_ready), .tx_valid(s_txv),
    .tx_data(s_txd), .tx_ready(s_txr), .grant_id(s_gid),
    .busy(s_busy), .timeout_evt(s_to)
  );

  int nchk = 0;
  int nfail = 0;

  // Per-requester packet buffers: {last, byte}
  logic [8:0] pbuf [N][16];
  int         phead [N];
  int         plen [N];
  logic [7:0] exp_q [$];
  int         mptr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pending(input int i);
    return plen[i] - phead[i];
  endfunction

  task automatic push_byte(input int i, input logic [7:0] b, input bit last);
    pbuf[i][plen[i]] = {last, b};
    plen[i]++;
  endtask

  task automatic clear_bufs();
    for (int i = 0; i < N; i++) begin
      phead[i] = 0;
      plen[i]  = 0;
    end
    exp_q.delete();
  endtask

  task automatic drive_req(input int i);
    if (pending(i) > 0) begin
      req_data[8*i +: 8] = pbuf[i][phead[i]][7:0];
      req_last[i]        = pbuf[i][phead[i]][8];
    end else begin
      req_data[8*i +: 8] = 8'h00;
      req_last[i]        = 1'b0;
    end
  endtask

  // mode 0: tx_ready=1, requesters never pause
  // mode 1: random tx_ready and random requester gaps (shorter than the timeout)
  // mode 2: tx_ready low for cycles 1..5 and 8..12
  task automatic run_phase(input int mode, input int abort_after, output int cycles);
    int ntx, idle_run, last_idx, idx;
    int gap [N];
    bit abandoned, done, all_empty;
    logic [N-1:0] rf;
    bit prev_v, prev_r;
    logic [7:0] prev_d;

    last_idx = -1;
    for (int off = 1; off <= N; off++) begin
      idx = (mptr + off) % N;
      if (pending(idx) > 0) begin
        exp_q.push_back({4'hA, 4'(idx)});
        for (int b = phead[idx]; b < plen[idx]; b++) exp_q.push_back(pbuf[idx][b][7:0]);
        last_idx = idx;
      end
    end
    if (last_idx >= 0) mptr = last_idx;

    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      drive_req(i);
      req_valid[i] = (pending(i) > 0);
      gap[i] = 0;
    end
    tx_ready = 1'b1;
    ntx = 0; idle_run = 0; abandoned = 0; done = 0; cycles = 0;
    prev_v = 0; prev_r = 0; prev_d = 8'h00; rf = '0;

    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      cycles = cyc;
      if (abandoned) idle_run++;
      check("timeout_evt", 32'(timeout_evt), 32'(abandoned && idle_run == TO));
      if (abandoned && idle_run == TO) abandoned = 0;
      if (prev_v && !prev_r) begin
        check("hold_valid", 32'(tx_valid), 32'd1);
        check("hold_data", 32'(tx_data), 32'(prev_d));
      end
      if (tx_valid && tx_ready) begin
        nchk++;
        assert (exp_q.size() != 0) else begin
          nfail++;
          $error("FAIL tx_extra: observed byte %0h expected no byte", tx_data);
        end
        if (exp_q.size() != 0) check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
        ntx++;
      end
      all_empty = 1;
      for (int i = 0; i < N; i++) begin
        rf[i] = req_valid[i] && req_ready[i];
        if (rf[i]) begin
          if (!pbuf[i][phead[i]][8] && pending(i) == 1) begin
            abandoned = 1;
            idle_run  = 0;
          end
          phead[i]++;
        end
        if (pending(i) > 0) all_empty = 0;
      end
      prev_v = tx_valid; prev_r = tx_ready; prev_d = tx_data;
      if (abort_after > 0 && ntx >= abort_after) done = 1;
      else if (all_empty && exp_q.size() == 0 && !busy && !abandoned) done = 1;
      if (!done) begin
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
          if (pending(i) == 0) begin
            req_valid[i] = 1'b0;
          end else if (rf[i] || !req_valid[i]) begin
            if (mode == 1 && gap[i] < 3 && $urandom_range(0, 1) == 0) begin
              req_valid[i] = 1'b0;
              gap[i]++;
            end else begin
              req_valid[i] = 1'b1;
              gap[i] = 0;
              drive_req(i);
            end
          end
        end
        if (mode == 1) tx_ready = ($urandom_range(0, 3) != 0);
        else if (mode == 2) tx_ready = !(((cyc + 1) >= 1 && (cyc + 1) <= 5) ||
                                         ((cyc + 1) >= 8 && (cyc + 1) <= 12));
        else tx_ready = 1'b1;
      end
    end
    nchk++;
    assert (done) else begin
      nfail++;
      $error("FAIL phase_budget: observed %0d bytes pending expected 0", exp_q.size());
    end
    if (abort_after == 0 && last_idx >= 0) check("grant_id", 32'(grant_id), 32'(mptr));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit any;
    rst = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b0;
    s_valid = '0; s_last = '0; s_data = 8'h00; s_txr = 1'b0;
    clear_bufs();
    mptr = N - 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout", 32'(timeout_evt), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst1_tx_valid", 32'(s_txv), 32'd0);
    check("rst1_busy", 32'(s_busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Three-byte packet from req0, ready always high
    push_byte(0, 8'h11, 0); push_byte(0, 8'h22, 0); push_byte(0, 8'h33, 1);
    run_phase(0, 0, cyc);
    check("t1_release_cycle", 32'(cyc), 32'd5);

    // All four with single-byte packets, then req0 again (wrap)
    for (int i = 0; i < N; i++) push_byte(i, 8'(8'h40 + i), 1);
    run_phase(0, 0, cyc);
    push_byte(0, 8'h99, 1);
    run_phase(0, 0, cyc);

    // Backpressure during TAG and DATA
    push_byte(1, 8'hC1, 0); push_byte(1, 8'hC2, 0); push_byte(1, 8'hC3, 0); push_byte(1, 8'hC4, 1);
    run_phase(2, 0, cyc);

    // req2 stalls after a non-final byte; req3 is waiting
    push_byte(2, 8'h5C, 0);
    push_byte(3, 8'h77, 1);
    run_phase(0, 0, cyc);

    // Randomized packet mixes
    for (int ph = 0; ph < 6; ph++) begin
      any = 0;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) == 1 || (!any && i == N - 1)) begin
          int len;
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) push_byte(i, 8'($urandom_range(0, 255)), b == len - 1);
          any = 1;
        end
      end
      run_phase(1, 0, cyc);
    end

    // Reset in the middle of a req1 packet
    push_byte(1, 8'hD1, 0); push_byte(1, 8'hD2, 0); push_byte(1, 8'hD3, 0); push_byte(1, 8'hD4, 1);
    run_phase(0, 2, cyc);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_timeout", 32'(timeout_evt), 32'd0);
    check("mid_rst_grant_id", 32'(grant_id), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '0; req_last = '0;
    clear_bufs();
    mptr = N - 1;
    push_byte(1, 8'hE1, 1);
    push_byte(0, 8'hE0, 0); push_byte(0, 8'hE2, 1);
    run_phase(1, 0, cyc);

    // Single requester, no tags, no timeout
    @(posedge clk); #1;
    s_txr = 1'b1; s_valid = 1'b1; s_data = 8'h3C; s_last = 1'b0;
    @(negedge clk);
    check("s_arb_latency", 32'(s_txv), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("s_pass_valid", 32'(s_txv), 32'd1);
    check("s_pass_data", 32'(s_txd), 32'h3C);
    check("s_ready", 32'(s_ready), 32'd1);
    check("s_grant_id", 32'(s_gid), 32'd0);
    @(posedge clk); #1;
    s_data = 8'h4D; s_last = 1'b1;
    @(negedge clk);
    check("s_zero_latency", 32'(s_txd), 32'h4D);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    check("s_release_busy", 32'(s_busy), 32'd0);
    check("s_release_valid", 32'(s_txv), 32'd0);
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = 8'h55;
    @(posedge clk); #1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("s_no_timeout", 32'(s_to), 32'd0);
    end
    check("s_grant_held", 32'(s_busy), 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = 8'h66; s_last = 1'b1;
    @(negedge clk);
    check("s_late_byte", 32'(s_txd), 32'h66);
    check("s_late_valid", 32'(s_txv), 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    check("s_final_busy", 32'(s_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule
